// File: rtl/alu_muldiv_seq_pkg.sv
// Shared definitions for the multiply/divide sequencer and its neighbours
// (my_ALU, decoder): sequencer state encoding, my_ALU opcodes used by the
// sequencer, and the datapath width.
package alu_muldiv_seq_pkg;

  localparam int P_W      = 16;            // datapath width and iteration count
  localparam int OP_W     = 5;             // my_ALU opcode width
  localparam int CNT_W    = $clog2(P_W);   // iteration counter width

  localparam logic [OP_W-1:0] P_OP_ADD = 5'b01000;  // A+B+cf, cf = carry out
  localparam logic [OP_W-1:0] P_OP_SUB = 5'b01001;  // A-B, cf = borrow (A<B)

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(P_W - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_DONE = 2'd3
  } seq_state_t;

endpackage

// File: rtl/alu_muldiv_seq_alu_port_mux.sv
// alu_port_mux: selects what drives my_ALU's inputs. With sel_seq low the
// pipeline operands pass straight through; with sel_seq high the sequencer
// owns the ALU.
// Ports:
//   sel_seq                          in   1 = sequencer drives the ALU
//   pipe_a/pipe_b/pipe_op/pipe_cf    in   pipeline ALU request
//   seq_a/seq_b/seq_op/seq_cf        in   sequencer ALU request
//   alu_a/alu_b/alu_op/alu_cf        out  to my_ALU in_A/in_B/op/cf
module alu_port_mux
  import alu_muldiv_seq_pkg::*;
(
  input  logic             sel_seq,
  input  logic [P_W-1:0]   pipe_a,
  input  logic [P_W-1:0]   pipe_b,
  input  logic [OP_W-1:0]  pipe_op,
  input  logic             pipe_cf,
  input  logic [P_W-1:0]   seq_a,
  input  logic [P_W-1:0]   seq_b,
  input  logic [OP_W-1:0]  seq_op,
  input  logic             seq_cf,
  output logic [P_W-1:0]   alu_a,
  output logic [P_W-1:0]   alu_b,
  output logic [OP_W-1:0]  alu_op,
  output logic             alu_cf
);

  assign alu_a  = sel_seq ? seq_a  : pipe_a;
  assign alu_b  = sel_seq ? seq_b  : pipe_b;
  assign alu_op = sel_seq ? seq_op : pipe_op;
  assign alu_cf = sel_seq ? seq_cf : pipe_cf;

endmodule

// File: rtl/alu_muldiv_seq.sv
// alu_muldiv_seq: multi-cycle 16x16 unsigned multiply / 16/16 unsigned divide
// that borrows the shared my_ALU once per iteration (ADD for shift-add
// multiply, SUB for restoring divide). When idle the pipeline owns the ALU;
// when busy the sequencer owns it and pipeline requests are stalled.
// Ports:
//   in_clk, in_rst                    clock, async active-high reset
//   in_start, in_is_div               start request (IDLE only), 1 = divide
//   in_opa, in_opb                    multiplicand/dividend, multiplier/divisor
//   out_busy, out_done                busy flag, one-cycle result pulse
//   out_lo, out_hi                    product low/quotient, product high/remainder
//   out_div0                          divide-by-zero flag, held until next start
//   in_pipe_A/B/op/cf, in_pipe_valid  pipeline ALU request
//   out_stall                         pipeline must hold its request
//   out_alu_A/B/op/cf                 to my_ALU
//   in_alu_C, in_alu_cf               from my_ALU
module alu_muldiv_seq
  import alu_muldiv_seq_pkg::*;
(
  input  logic             in_clk,
  input  logic             in_rst,
  input  logic             in_start,
  input  logic             in_is_div,
  input  logic [P_W-1:0]   in_opa,
  input  logic [P_W-1:0]   in_opb,
  output logic             out_busy,
  output logic             out_done,
  output logic [P_W-1:0]   out_lo,
  output logic [P_W-1:0]   out_hi,
  output logic             out_div0,
  input  logic [P_W-1:0]   in_pipe_A,
  input  logic [P_W-1:0]   in_pipe_B,
  input  logic [OP_W-1:0]  in_pipe_op,
  input  logic             in_pipe_cf,
  input  logic             in_pipe_valid,
  output logic             out_stall,
  output logic [P_W-1:0]   out_alu_A,
  output logic [P_W-1:0]   out_alu_B,
  output logic [OP_W-1:0]  out_alu_op,
  output logic             out_alu_cf,
  input  logic [P_W-1:0]   in_alu_C,
  input  logic             in_alu_cf
);

  seq_state_t       state;
  logic [CNT_W-1:0] cnt;
  logic [P_W-1:0]   mcand;    // latched multiplicand
  logic [P_W-1:0]   divisor;  // latched divisor
  logic [P_W-1:0]   hi;
  logic [P_W-1:0]   lo;

  logic [P_W:0]     div_s;    // partial remainder shifted left by one dividend bit
  logic             div_ge;   // partial remainder >= divisor
  logic [P_W-1:0]   iter_hi;
  logic [P_W-1:0]   iter_lo;
  logic [P_W-1:0]   seq_a;
  logic [P_W-1:0]   seq_b;
  logic [OP_W-1:0]  seq_op;
  logic             seq_cf;

  // Sequencer's ALU request and the next {hi,lo} for one iteration.
  // NOTE: every signal written here gets a default first so no latch is inferred.
  always_comb begin
    seq_a   = hi;
    seq_b   = '0;
    seq_op  = P_OP_ADD;
    seq_cf  = 1'b0;
    div_s   = {hi, lo[P_W-1]};
    // A set bit 16 means s >= 2^16 > divisor, so the subtract is always taken.
    div_ge  = div_s[P_W] | ~in_alu_cf;
    iter_hi = hi;
    iter_lo = lo;
    case (state)
      S_MUL: begin
        seq_b = lo[0] ? mcand : '0;
        // Shift {carry, sum, multiplier} right by one.
        {iter_hi, iter_lo} = {in_alu_cf, in_alu_C, lo[P_W-1:1]};
      end
      S_DIV: begin
        seq_a   = div_s[P_W-1:0];
        seq_b   = divisor;
        seq_op  = P_OP_SUB;
        iter_hi = div_ge ? in_alu_C : div_s[P_W-1:0];
        iter_lo = {lo[P_W-2:0], div_ge};
      end
      default: ;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge in_clk or posedge in_rst) begin
    if (in_rst) begin
      state    <= S_IDLE;
      cnt      <= '0;
      mcand    <= '0;
      divisor  <= '0;
      hi       <= '0;
      lo       <= '0;
      out_busy <= 1'b0;
      out_done <= 1'b0;
      out_div0 <= 1'b0;
      out_lo   <= '0;
      out_hi   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_start) begin
            mcand    <= in_opa;
            divisor  <= in_opb;
            cnt      <= '0;
            out_busy <= 1'b1;
            if (in_is_div && (in_opb == '0)) begin
              // Divide by zero skips the iterations entirely.
              state    <= S_DONE;
              hi       <= in_opa;
              lo       <= '1;
              out_hi   <= in_opa;
              out_lo   <= '1;
              out_div0 <= 1'b1;
              out_done <= 1'b1;
            end else begin
              state    <= in_is_div ? S_DIV : S_MUL;
              hi       <= '0;
              lo       <= in_is_div ? in_opa : in_opb;
              out_div0 <= 1'b0;
            end
          end
        end
        S_MUL, S_DIV: begin
          hi  <= iter_hi;
          lo  <= iter_lo;
          cnt <= cnt + CNT_W'(1);
          if (cnt == CNT_LAST) begin
            state    <= S_DONE;
            out_hi   <= iter_hi;
            out_lo   <= iter_lo;
            out_done <= 1'b1;
          end
        end
        S_DONE: begin
          state    <= S_IDLE;
          out_busy <= 1'b0;
          out_done <= 1'b0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign out_stall = out_busy & in_pipe_valid;

  alu_port_mux u_alu_port_mux (
    .sel_seq (out_busy),
    .pipe_a  (in_pipe_A),
    .pipe_b  (in_pipe_B),
    .pipe_op (in_pipe_op),
    .pipe_cf (in_pipe_cf),
    .seq_a   (seq_a),
    .seq_b   (seq_b),
    .seq_op  (seq_op),
    .seq_cf  (seq_cf),
    .alu_a   (out_alu_A),
    .alu_b   (out_alu_B),
    .alu_op  (out_alu_op),
    .alu_cf  (out_alu_cf)
  );

endmodule

// File: tb/tb_alu_muldiv_seq.sv
// Self-checking bench for alu_muldiv_seq with a behavioural stand-in for
// my_ALU (ADD with carry, SUB with borrow) wired to the ALU ports.
module tb_alu_muldiv_seq;
  import alu_muldiv_seq_pkg::*;

  logic             in_clk = 1'b0;
  logic             in_rst;
  logic             in_start;
  logic             in_is_div;
  logic [P_W-1:0]   in_opa;
  logic [P_W-1:0]   in_opb;
  logic             out_busy;
  logic             out_done;
  logic [P_W-1:0]   out_lo;
  logic [P_W-1:0]   out_hi;
  logic             out_div0;
  logic [P_W-1:0]   in_pipe_A;
  logic [P_W-1:0]   in_pipe_B;
  logic [OP_W-1:0]  in_pipe_op;
  logic             in_pipe_cf;
  logic             in_pipe_valid;
  logic             out_stall;
  logic [P_W-1:0]   out_alu_A;
  logic [P_W-1:0]   out_alu_B;
  logic [OP_W-1:0]  out_alu_op;
  logic             out_alu_cf;
  logic [P_W-1:0]   in_alu_C;
  logic             in_alu_cf;
  logic [P_W:0]     alu_sum;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 in_clk = ~in_clk;

  alu_muldiv_seq dut (
    .in_clk        (in_clk),
    .in_rst        (in_rst),
    .in_start      (in_start),
    .in_is_div     (in_is_div),
    .in_opa        (in_opa),
    .in_opb        (in_opb),
    .out_busy      (out_busy),
    .out_done      (out_done),
    .out_lo        (out_lo),
    .out_hi        (out_hi),
    .out_div0      (out_div0),
    .in_pipe_A     (in_pipe_A),
    .in_pipe_B     (in_pipe_B),
    .in_pipe_op    (in_pipe_op),
    .in_pipe_cf    (in_pipe_cf),
    .in_pipe_valid (in_pipe_valid),
    .out_stall     (out_stall),
    .out_alu_A     (out_alu_A),
    .out_alu_B     (out_alu_B),
    .out_alu_op    (out_alu_op),
    .out_alu_cf    (out_alu_cf),
    .in_alu_C      (in_alu_C),
    .in_alu_cf     (in_alu_cf)
  );

  // my_ALU stand-in.
  always_comb begin
    case (out_alu_op)
      P_OP_ADD: alu_sum = {1'b0, out_alu_A} + {1'b0, out_alu_B} + {{P_W{1'b0}}, out_alu_cf};
      P_OP_SUB: alu_sum = {1'b0, out_alu_A} - {1'b0, out_alu_B};
      default:  alu_sum = {1'b0, out_alu_A ^ out_alu_B};
    endcase
  end
  assign in_alu_C  = alu_sum[P_W-1:0];
  assign in_alu_cf = alu_sum[P_W];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge in_clk);
    #1;
  endtask

  // Start one operation, wait for out_done (bounded), check results and the
  // return to IDLE. With poke set, also checks the stall/mux during the
  // iterations and that in_start while busy or in DONE is ignored.
  task automatic run_op(input string name, input logic is_div,
                        input logic [P_W-1:0] a, input logic [P_W-1:0] b,
                        input logic [P_W-1:0] exp_lo, input logic [P_W-1:0] exp_hi,
                        input logic exp_div0, input int exp_lat, input logic poke);
    int lat;
    in_start  = 1'b1;
    in_is_div = is_div;
    in_opa    = a;
    in_opb    = b;
    tick();
    in_start  = 1'b0;
    in_opa    = ~a;   // operands are latched; later changes must not matter
    in_opb    = ~b;
    lat = 0;
    while (!out_done && lat < 40) begin
      if (poke && lat == 4) begin
        check({name, " busy_mid"}, 32'(out_busy), 32'd1);
        in_pipe_valid = 1'b1;
        in_pipe_op    = 5'b00011;
        #1;
        check({name, " stall"}, 32'(out_stall), 32'd1);
        check({name, " alu_op_seq"}, 32'(out_alu_op), 32'(is_div ? P_OP_SUB : P_OP_ADD));
        in_start = 1'b1;
        in_opa   = 16'h0002;
        in_opb   = 16'h0002;
      end
      tick();
      in_start      = 1'b0;
      in_pipe_valid = 1'b0;
      in_pipe_op    = P_OP_ADD;
      lat++;
    end
    check({name, " latency"}, 32'(lat), 32'(exp_lat));
    check({name, " lo"}, 32'(out_lo), 32'(exp_lo));
    check({name, " hi"}, 32'(out_hi), 32'(exp_hi));
    check({name, " div0"}, 32'(out_div0), 32'(exp_div0));
    check({name, " busy_done"}, 32'(out_busy), 32'd1);
    if (poke) in_start = 1'b1;
    tick();
    in_start = 1'b0;
    check({name, " done_pulse"}, 32'(out_done), 32'd0);
    check({name, " busy_idle"}, 32'(out_busy), 32'd0);
    check({name, " lo_hold"}, 32'(out_lo), 32'(exp_lo));
    check({name, " hi_hold"}, 32'(out_hi), 32'(exp_hi));
    if (poke) begin
      tick();
      check({name, " start_in_done_ignored"}, 32'(out_busy), 32'd0);
    end
  endtask

  initial begin
    in_rst        = 1'b1;
    in_start      = 1'b0;
    in_is_div     = 1'b0;
    in_opa        = '0;
    in_opb        = '0;
    in_pipe_A     = '0;
    in_pipe_B     = '0;
    in_pipe_op    = '0;
    in_pipe_cf    = 1'b0;
    in_pipe_valid = 1'b0;
    #1;
    check("rst busy", 32'(out_busy), 32'd0);
    check("rst done", 32'(out_done), 32'd0);
    check("rst div0", 32'(out_div0), 32'd0);
    check("rst lo",   32'(out_lo),   32'd0);
    check("rst hi",   32'(out_hi),   32'd0);
    tick();
    tick();
    in_rst = 1'b0;
    tick();

    // Idle pass-through of a pipeline ADD.
    in_pipe_A     = 16'd3;
    in_pipe_B     = 16'd4;
    in_pipe_op    = P_OP_ADD;
    in_pipe_valid = 1'b1;
    #1;
    check("pipe alu_A",  32'(out_alu_A),  32'd3);
    check("pipe alu_B",  32'(out_alu_B),  32'd4);
    check("pipe alu_op", 32'(out_alu_op), 32'(5'b01000));
    check("pipe alu_cf", 32'(out_alu_cf), 32'd0);
    check("pipe alu_C",  32'(in_alu_C),   32'd7);
    check("pipe stall",  32'(out_stall),  32'd0);
    in_pipe_valid = 1'b0;
    tick();

    run_op("mul 3*4",         1'b0, 16'd3,     16'd4,     16'd12,    16'h0000, 1'b0, 16, 1'b1);
    run_op("mul FFFF*FFFF",   1'b0, 16'hFFFF,  16'hFFFF,  16'h0001,  16'hFFFE, 1'b0, 16, 1'b0);
    run_op("mul 1234*5678",   1'b0, 16'h1234,  16'h5678,  16'h0060,  16'h0626, 1'b0, 16, 1'b0);
    run_op("div 100/7",       1'b1, 16'd100,   16'd7,     16'd14,    16'd2,    1'b0, 16, 1'b1);
    run_op("div FFFF/1",      1'b1, 16'hFFFF,  16'd1,     16'hFFFF,  16'h0000, 1'b0, 16, 1'b0);
    run_op("div 8000/3",      1'b1, 16'h8000,  16'd3,     16'h2AAA,  16'h0002, 1'b0, 16, 1'b0);
    run_op("div 3/10",        1'b1, 16'd3,     16'd10,    16'h0000,  16'h0003, 1'b0, 16, 1'b0);
    run_op("div 5/0",         1'b1, 16'd5,     16'd0,     16'hFFFF,  16'h0005, 1'b1, 0,  1'b0);
    tick();
    check("div0 held", 32'(out_div0), 32'd1);
    run_op("mul after div0",  1'b0, 16'd7,     16'd9,     16'd63,    16'h0000, 1'b0, 16, 1'b0);

    // Reset in the middle of a multiply.
    in_pipe_A  = 16'h00AA;
    in_pipe_op = 5'b00011;
    in_start   = 1'b1;
    in_is_div  = 1'b0;
    in_opa     = 16'hFFFF;
    in_opb     = 16'hFFFF;
    tick();
    in_start = 1'b0;
    for (int i = 0; i < 8; i++) tick();
    check("abort busy_before", 32'(out_busy), 32'd1);
    in_rst = 1'b1;
    #1;
    check("abort busy",  32'(out_busy),   32'd0);
    check("abort done",  32'(out_done),   32'd0);
    check("abort lo",    32'(out_lo),     32'd0);
    check("abort hi",    32'(out_hi),     32'd0);
    check("abort mux_A", 32'(out_alu_A),  32'h00AA);
    check("abort mux_op",32'(out_alu_op), 32'(5'b00011));
    tick();
    in_rst = 1'b0;
    tick();
    run_op("mul after rst",   1'b0, 16'd3,     16'd4,     16'd12,    16'h0000, 1'b0, 16, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
